// File: rtl/regfile_op_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_op_sequencer
//
// Command-driven initiator for the 4x16 register file. It accepts one
// register-to-register operation per command handshake, reads both operands
// through the file's combinational read ports, computes the result, writes it
// back through the file's synchronous write port and returns the result on a
// response handshake. It is the only block that drives the file's write port.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_op                     00 ADD, 01 SUB, 10 AND, 11 READ
//   cmd_dst/srcA/srcB          destination and operand register addresses
//   rf_write/wrAddr/wrData     register-file write port (one-cycle pulse)
//   rf_rdAddrA/B, rf_rdDataA/B register-file read ports (combinational data)
//   rsp_valid / rsp_ready      response handshake
//   rsp_data, rsp_err          result and address-error flag
// ---------------------------------------------------------------------------
module regfile_op_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_srcA,
    input  logic [ADDR_W-1:0] cmd_srcB,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_wrAddr,
    output logic [DATA_W-1:0] rf_wrData,
    output logic [ADDR_W-1:0] rf_rdAddrA,
    input  logic [DATA_W-1:0] rf_rdDataA,
    output logic [ADDR_W-1:0] rf_rdAddrB,
    input  logic [DATA_W-1:0] rf_rdDataB,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    // Highest implemented register; anything above is an address error.
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(3);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WB,
        RESP
    } state_t;

    state_t state;

    logic [1:0]               op_p0;
    logic [ADDR_W-1:0]        dst_p0;
    logic                     err_p0;
    logic signed [DATA_W-1:0] opA_p1;
    logic signed [DATA_W-1:0] opB_p1;
    logic signed [DATA_W-1:0] result_p2;

    // Two's complement add/sub wrap naturally at DATA_W bits.
    function automatic logic signed [DATA_W-1:0] aluResult(
        input logic [1:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        case (op)
            OP_ADD:  aluResult = a + b;
            OP_SUB:  aluResult = a - b;
            OP_AND:  aluResult = a & b;
            default: aluResult = a;
        endcase
    endfunction

    // READ only uses srcA; dst and srcB are don't-cares for it.
    function automatic logic addrErr(
        input logic [1:0]        op,
        input logic [ADDR_W-1:0] dst,
        input logic [ADDR_W-1:0] srcA,
        input logic [ADDR_W-1:0] srcB
    );
        if (op == OP_READ)
            addrErr = (srcA > MAX_ADDR);
        else
            addrErr = (dst > MAX_ADDR) || (srcA > MAX_ADDR) || (srcB > MAX_ADDR);
    endfunction

    // Datapath registers carry no reset: each is written before it is used.
    always_ff @(posedge clk) begin
        // p0: command fields latched on accept
        if (state == IDLE && cmd_valid) begin
            op_p0  <= cmd_op;
            dst_p0 <= cmd_dst;
        end
        // p1: operands captured from the read ports
        if (state == READ) begin
            opA_p1 <= $signed(rf_rdDataA);
            opB_p1 <= $signed(rf_rdDataB);
        end
        // p2: result
        if (state == EXEC)
            result_p2 <= aluResult(op_p0, opA_p1, opB_p1);
    end

    // Control FSM with registered outputs. The asynchronous reset drops
    // rf_write immediately so an aborted operation never commits a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            err_p0     <= 1'b0;
            rf_write   <= 1'b0;
            rf_wrAddr  <= '0;
            rf_wrData  <= '0;
            rf_rdAddrA <= '0;
            rf_rdAddrB <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready  <= 1'b0;
                        rf_rdAddrA <= cmd_srcA;
                        rf_rdAddrB <= cmd_srcB;
                        err_p0     <= addrErr(cmd_op, cmd_dst, cmd_srcA, cmd_srcB);
                        state      <= READ;
                    end
                end
                READ: begin
                    state <= EXEC;
                end
                EXEC: begin
                    // Write data is taken straight from the ALU so the pulse
                    // lands in WB alongside the registered result.
                    if (!err_p0 && op_p0 != OP_READ) begin
                        rf_write  <= 1'b1;
                        rf_wrAddr <= dst_p0;
                        rf_wrData <= $unsigned(aluResult(op_p0, opA_p1, opB_p1));
                    end
                    state <= WB;
                end
                WB: begin
                    rf_write  <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= err_p0 ? '0 : $unsigned(result_p2);
                    rsp_err   <= err_p0;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    rf_write  <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_regfile_op_sequencer
//
// Bench for regfile_op_sequencer. Provides a behavioural 4x16 register file
// on the sequencer's ports and keeps an independent copy of the expected
// register contents, from which each response and write is predicted.
// ---------------------------------------------------------------------------
module tb_regfile_op_sequencer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W-1:0] cmd_srcA;
    logic [ADDR_W-1:0] cmd_srcB;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_wrAddr;
    logic [DATA_W-1:0] rf_wrData;
    logic [ADDR_W-1:0] rf_rdAddrA;
    logic [DATA_W-1:0] rf_rdDataA;
    logic [ADDR_W-1:0] rf_rdAddrB;
    logic [DATA_W-1:0] rf_rdDataB;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    int vectors = 0;
    int miscompares = 0;
    int wrCount = 0;
    int cyc = 0;
    int lastAccept = 0;

    logic [15:0] rf[4];
    logic [15:0] model[4];
    logic        preEn = 1'b0;
    logic [1:0]  preAddr = 2'd0;
    logic [15:0] preData = 16'd0;

    always #5 clk = ~clk;

    regfile_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_srcA(cmd_srcA), .cmd_srcB(cmd_srcB),
        .rf_write(rf_write), .rf_wrAddr(rf_wrAddr), .rf_wrData(rf_wrData),
        .rf_rdAddrA(rf_rdAddrA), .rf_rdDataA(rf_rdDataA),
        .rf_rdAddrB(rf_rdAddrB), .rf_rdDataB(rf_rdDataB),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    // Behavioural register file: combinational reads, synchronous write.
    assign rf_rdDataA = (rf_rdAddrA < 3'd4) ? rf[rf_rdAddrA[1:0]] : 16'hBAD0;
    assign rf_rdDataB = (rf_rdAddrB < 3'd4) ? rf[rf_rdAddrB[1:0]] : 16'hBAD1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_write === 1'b1) begin
            wrCount <= wrCount + 1;
            if (rf_wrAddr < 3'd4) rf[rf_wrAddr[1:0]] <= rf_wrData;
        end else if (preEn) begin
            rf[preAddr] <= preData;
        end
    end

    task automatic preload(input logic [1:0] addr, input logic [15:0] data);
        preAddr = addr;
        preData = data;
        preEn   = 1'b1;
        @(posedge clk); #1;
        preEn   = 1'b0;
        model[addr] = data;
    endtask

    // Issue one command and follow it through every state, comparing the
    // sequencer against the predicted write and response.
    task automatic runCmd(input logic [1:0] op, input logic [2:0] d, input logic [2:0] a,
                          input logic [2:0] b, input int hold);
        logic        expErr;
        logic        expWr;
        logic [15:0] expData;
        int          ia, ib, r, w0;
        expErr = (op == OP_READ) ? (a > 3) : (d > 3 || a > 3 || b > 3);
        ia = (a < 4) ? int'(model[a[1:0]]) : 0;
        ib = (b < 4) ? int'(model[b[1:0]]) : 0;
        case (op)
            OP_ADD:  r = (ia + ib) % 65536;
            OP_SUB:  r = (ia - ib + 65536) % 65536;
            OP_AND:  r = ia & ib;
            default: r = ia;
        endcase
        expData = expErr ? 16'h0000 : 16'(r);
        expWr   = !expErr && (op != OP_READ);

        rsp_ready = (hold == 0);
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready === 1'b1) break;
            @(posedge clk); #1;
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_ready_wait: got %b required 1", cmd_ready);
        end
        w0 = wrCount;
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = d; cmd_srcA = a; cmd_srcB = b;
        @(posedge clk); #1;                     // E0 accepted
        lastAccept = cyc;
        cmd_valid = 1'b0;
        vectors++;
        if ({cmd_ready, rf_rdAddrA, rf_rdAddrB} !== {1'b0, a, b}) begin
            miscompares++;
            $display("FAIL accept: got rdy=%b rdA=%0d rdB=%0d required 0 %0d %0d",
                     cmd_ready, rf_rdAddrA, rf_rdAddrB, a, b);
        end
        @(posedge clk); #1;                     // E1
        vectors++;
        if ({rsp_valid, rf_write} !== 2'b00) begin
            miscompares++;
            $display("FAIL exec_quiet: got valid=%b write=%b required 0 0", rsp_valid, rf_write);
        end
        @(posedge clk); #1;                     // E2: WB cycle
        vectors++;
        if (rf_write !== expWr || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wb_write: got write=%b valid=%b required %b 0", rf_write, rsp_valid, expWr);
        end
        if (expWr) begin
            vectors++;
            if ({rf_wrAddr, rf_wrData} !== {d, expData}) begin
                miscompares++;
                $display("FAIL wb_data: got addr=%0d data=%h required %0d %h",
                         rf_wrAddr, rf_wrData, d, expData);
            end
        end
        @(posedge clk); #1;                     // E3: response up
        vectors++;
        if ({rsp_valid, rsp_err, rsp_data, rf_write} !== {1'b1, expErr, expData, 1'b0}) begin
            miscompares++;
            $display("FAIL response: got valid=%b err=%b data=%h write=%b required 1 %b %h 0",
                     rsp_valid, rsp_err, rsp_data, rf_write, expErr, expData);
        end
        for (int i = 0; i < hold; i++) begin
            if (i == hold / 2) begin
                cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_dst = 3'd3; cmd_srcA = 3'd0; cmd_srcB = 3'd0;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk); #1;
            vectors++;
            if ({rsp_valid, rsp_err, rsp_data, cmd_ready} !== {1'b1, expErr, expData, 1'b0}) begin
                miscompares++;
                $display("FAIL hold_stable: got valid=%b err=%b data=%h rdy=%b required 1 %b %h 0",
                         rsp_valid, rsp_err, rsp_data, cmd_ready, expErr, expData);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;                     // handshake -> IDLE
        vectors++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL handshake: got valid=%b rdy=%b required 0 1", rsp_valid, cmd_ready);
        end
        if (expWr) model[d[1:0]] = expData;
        vectors++;
        if (wrCount - w0 !== int'(expWr)) begin
            miscompares++;
            $display("FAIL write_count: got %0d required %0d", wrCount - w0, int'(expWr));
        end
        vectors++;
        if ({rf[0], rf[1], rf[2], rf[3]} !== {model[0], model[1], model[2], model[3]}) begin
            miscompares++;
            $display("FAIL regs: got %h %h %h %h required %h %h %h %h",
                     rf[0], rf[1], rf[2], rf[3], model[0], model[1], model[2], model[3]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
        end
        vectors++;
        if ({rf_write, rf_wrAddr, rf_wrData} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_write_port: got %b %0d %h required 0 0 0", rf_write, rf_wrAddr, rf_wrData);
        end
        vectors++;
        if ({rf_rdAddrA, rf_rdAddrB} !== 6'd0) begin
            miscompares++; $display("FAIL reset_rd_addr: got %0d %0d required 0 0", rf_rdAddrA, rf_rdAddrB);
        end
        vectors++;
        if ({rsp_valid, rsp_data, rsp_err} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_rsp: got %b %h %b required 0 0 0", rsp_valid, rsp_data, rsp_err);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            miscompares++; $display("FAIL idle_after_reset: got %b %b required 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_add();
        preload(2'd0, 16'h0000); preload(2'd1, 16'h0005);
        preload(2'd2, 16'h0003); preload(2'd3, 16'h0000);
        runCmd(OP_ADD, 3'd3, 3'd1, 3'd2, 0);
        vectors++;
        if (rf[3] !== 16'h0008) begin
            miscompares++; $display("FAIL add_r3: got %h required 0008", rf[3]);
        end
    endtask

    task automatic test_sub_wrap();
        preload(2'd1, 16'h0000); preload(2'd2, 16'h0001);
        runCmd(OP_SUB, 3'd0, 3'd1, 3'd2, 0);
        vectors++;
        if (rf[0] !== 16'hFFFF) begin
            miscompares++; $display("FAIL sub_wrap_r0: got %h required FFFF", rf[0]);
        end
    endtask

    task automatic test_read_back_to_back();
        int a0;
        runCmd(OP_READ, 3'd7, 3'd2, 3'd5, 0);   // dst/srcB unused by READ
        a0 = lastAccept;
        runCmd(OP_READ, 3'd0, 3'd0, 3'd0, 0);
        vectors++;
        if (lastAccept - a0 !== 5) begin
            miscompares++; $display("FAIL b2b_spacing: got %0d required 5", lastAccept - a0);
        end
    endtask

    task automatic test_error();
        runCmd(OP_AND, 3'd5, 3'd1, 3'd2, 0);
        runCmd(OP_READ, 3'd0, 3'd4, 3'd0, 0);
        runCmd(OP_ADD, 3'd1, 3'd0, 3'd7, 0);
    endtask

    task automatic test_backpressure();
        runCmd(OP_ADD, 3'd2, 3'd0, 3'd1, 10);
        @(posedge clk); #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL ignored_cmd: got rdy=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_reset_mid_exec();
        int w0;
        preload(2'd1, 16'h1234); preload(2'd2, 16'h0101); preload(2'd3, 16'h0202);
        w0 = wrCount;
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_dst = 3'd1; cmd_srcA = 3'd2; cmd_srcB = 3'd3;
        rsp_ready = 1'b1;
        @(posedge clk); #1;                     // accept
        cmd_valid = 1'b0;
        @(posedge clk); #1;                     // now in EXEC
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({cmd_ready, rf_write, rf_wrAddr, rf_wrData, rf_rdAddrA, rf_rdAddrB, rsp_valid, rsp_data, rsp_err}
            !== {1'b1, 1'b0, 3'd0, 16'd0, 3'd0, 3'd0, 1'b0, 16'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL exec_abort_outputs: got rdy=%b wr=%b wa=%0d wd=%h ra=%0d rb=%0d v=%b d=%h e=%b required reset values",
                     cmd_ready, rf_write, rf_wrAddr, rf_wrData, rf_rdAddrA, rf_rdAddrB, rsp_valid, rsp_data, rsp_err);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (wrCount !== w0 || rf[1] !== model[1]) begin
            miscompares++;
            $display("FAIL exec_abort_write: got writes=%0d r1=%h required %0d %h", wrCount - w0, rf[1], 0, model[1]);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            miscompares++; $display("FAIL exec_abort_idle: got %b %b required 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_wb();
        int w0;
        w0 = wrCount;
        cmd_valid = 1'b1; cmd_op = OP_SUB; cmd_dst = 3'd2; cmd_srcA = 3'd1; cmd_srcB = 3'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;                                     // in WB, write pulse up
        vectors++;
        if (rf_write !== 1'b1) begin
            miscompares++; $display("FAIL wb_pulse: got %b required 1", rf_write);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rf_write !== 1'b0) begin
            miscompares++; $display("FAIL wb_async_drop: got %b required 0", rf_write);
        end
        @(posedge clk); #1;
        vectors++;
        if (wrCount !== w0 || rf[2] !== model[2]) begin
            miscompares++;
            $display("FAIL wb_abort_write: got writes=%0d r2=%h required 0 %h", wrCount - w0, rf[2], model[2]);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                preload(2'($urandom_range(0, 3)), 16'($urandom));
            runCmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)),
                   3'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_dst = '0; cmd_srcA = '0; cmd_srcB = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 16'h0000;
        test_reset();
        test_add();
        test_sub_wrap();
        test_read_back_to_back();
        test_error();
        test_backpressure();
        test_reset_mid_exec();
        test_reset_mid_wb();
        runCmd(OP_ADD, 3'd0, 3'd1, 3'd2, 0);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
